// File: rtl/register_rx.sv
// -----------------------------------------------------------------------------
// register_rx
//   Serial receiver for a 4-bit word framed as: start (0), 4 data bits LSB
//   first, stop (1).  Each bit lasts CLKS_PER_BIT clock cycles.  The start
//   bit is re-checked half a bit after it is first seen.  Every later bit is
//   sampled one full bit period after the previous sample, so each sample
//   lands near the middle of its bit.
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-low reset
//   rx         : serial line, synchronous to clk, idles high
//   data_out   : last correctly received word
//   fn         : one-cycle pulse, frame received without error
//   frame_err  : one-cycle pulse, stop bit sampled as 0
//   busy       : high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module register_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [3:0] data_out,
  output logic       fn,
  output logic       frame_err,
  output logic       busy
);

  // The cycle counter only ever reaches CLKS_PER_BIT-1.
  localparam int             CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0]  BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
    S_STOP      = 3'd3,
    S_WAIT_IDLE = 3'd4
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_bit;
  logic [3:0]    r_shift;
  logic [3:0]    r_data;
  logic          r_fn;
  logic          r_ferr;
  logic          r_busy;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [1:0]    w_bit_nxt;
  logic [3:0]    w_shift_nxt;
  logic [3:0]    w_data_nxt;
  logic          w_fn_nxt;
  logic          w_ferr_nxt;
  logic          w_half_done;
  logic          w_bit_done;

  // r_cnt holds (edges since the last sample point) - 1, so a match here
  // means the current edge is the next sample point.
  assign w_half_done = (r_cnt == HALF_LAST);
  assign w_bit_done  = (r_cnt == BIT_LAST);

  // Next-state, counter, shift-register and output-pulse logic.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_fn_nxt    = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = CNT_ZERO;
        w_bit_nxt = 2'd0;
        if (rx == 1'b0) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_half_done) begin
          w_cnt_nxt = CNT_ZERO;
          // A line back high at mid-start is a glitch, not a frame.
          if (rx == 1'b0) begin
            w_state_nxt = S_DATA;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_DATA: begin
        if (w_bit_done) begin
          w_cnt_nxt          = CNT_ZERO;
          w_shift_nxt[r_bit] = rx;
          if (r_bit == 2'd3) begin
            w_bit_nxt   = 2'd0;
            w_state_nxt = S_STOP;
          end else begin
            w_bit_nxt   = r_bit + 2'd1;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_STOP: begin
        if (w_bit_done) begin
          w_cnt_nxt = CNT_ZERO;
          if (rx == 1'b1) begin
            w_data_nxt  = r_shift;
            w_fn_nxt    = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_WAIT_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_ONE;
        end
      end
      S_WAIT_IDLE: begin
        // A broken line held low must not look like a stream of start bits.
        w_cnt_nxt = CNT_ZERO;
        if (rx == 1'b1) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_WAIT_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = CNT_ZERO;
        w_bit_nxt   = 2'd0;
      end
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= CNT_ZERO;
      r_bit   <= 2'd0;
      r_shift <= 4'h0;
      r_data  <= 4'h0;
      r_fn    <= 1'b0;
      r_ferr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_fn    <= w_fn_nxt;
      r_ferr  <= w_ferr_nxt;
      // Registered copy of (next state != IDLE) so busy tracks the state.
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign data_out  = r_data;
  assign fn        = r_fn;
  assign frame_err = r_ferr;
  assign busy      = r_busy;

endmodule

// File: tb/tb_register_rx.sv
// -----------------------------------------------------------------------------
// tb_register_rx
//   Self-checking bench for register_rx with CLKS_PER_BIT = 4.  Each frame
//   sent pushes its expected pulse (kind, data_out, edge number) onto a
//   scoreboard queue; a monitor pops and compares whenever fn or frame_err
//   is seen.  Scenario tasks check levels (busy, data_out) inline.
// -----------------------------------------------------------------------------
module tb_register_rx;

  localparam int CPB = 4;
  localparam int H   = CPB / 2;

  typedef struct {
    logic       fn;
    logic       ferr;
    logic [3:0] data;
    int         cyc;
  } ev_t;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [3:0] data_out;
  logic       fn;
  logic       frame_err;
  logic       busy;

  int         cyc;
  int         n_tests;
  int         n_fail;
  logic [3:0] exp_data;
  ev_t        exp_q[$];

  register_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .fn        (fn),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the number of the last rising edge.
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Drives one frame starting at the current negedge; t is the edge that
  // first samples the start bit.  The stop bit lasts stop_len cycles.
  task automatic send_frame(input logic [3:0] d, input logic stop, input int stop_len,
                            output int t, output logic busy_seen);
    ev_t e;
    rx    = 1'b0;
    t     = cyc + 1;
    e.cyc = t + H + 5 * CPB;
    if (stop) begin
      e.fn = 1'b1; e.ferr = 1'b0; e.data = d; exp_data = d;
    end else begin
      e.fn = 1'b0; e.ferr = 1'b1; e.data = exp_data;
    end
    exp_q.push_back(e);
    @(negedge clk);
    busy_seen = busy;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (stop_len) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; rx = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL reset_data_out: got %h want 0", data_out); end
    n_tests++; if (fn !== 1'b0) begin n_fail++; $display("FAIL reset_fn: got %b want 0", fn); end
    n_tests++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    reset = 1'b1;
    exp_data = 4'h0;
  endtask

  task automatic test_good_frame();
    int t; logic b;
    send_frame(4'h6, 1'b1, CPB, t, b);
    n_tests++; if (b !== 1'b1) begin n_fail++; $display("FAIL good_busy_mid: got %b want 1", b); end
    rx = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL good_busy_after: got %b want 0", busy); end
    n_tests++; if (data_out !== 4'h6) begin n_fail++; $display("FAIL good_data_out: got %h want 6", data_out); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL good_missing_pulse: %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_false_start();
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_busy_t: got %b want 1", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL false_busy_t1: got %b want 1", busy); end
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL false_busy_t2: got %b want 0", busy); end
    repeat (8) @(negedge clk);
    n_tests++; if (data_out !== 4'h6) begin n_fail++; $display("FAIL false_data_out: got %h want 6", data_out); end
  endtask

  task automatic test_frame_error();
    int t; logic b;
    send_frame(4'h9, 1'b0, CPB, t, b);
    rx = 1'b0;
    repeat (10) @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ferr_wait_busy: got %b want 1", busy); end
    n_tests++; if (data_out !== 4'h6) begin n_fail++; $display("FAIL ferr_data_out: got %h want 6", data_out); end
    rx = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_release_busy: got %b want 0", busy); end
    repeat (4) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_idle_busy: got %b want 0", busy); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ferr_missing_pulse: %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_back_to_back();
    int t1, t2; logic b;
    send_frame(4'hA, 1'b1, CPB, t1, b);
    n_tests++; if (data_out !== 4'hA) begin n_fail++; $display("FAIL b2b_first_data: got %h want a", data_out); end
    send_frame(4'h5, 1'b1, CPB, t2, b);
    n_tests++; if (t2 - t1 != 24) begin n_fail++; $display("FAIL b2b_spacing: got %0d want 24", t2 - t1); end
    // Minimum gap: next start sampled on the edge right after the stop sample.
    send_frame(4'hC, 1'b1, H + 1, t1, b);
    send_frame(4'h3, 1'b1, CPB, t2, b);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (data_out !== 4'h3) begin n_fail++; $display("FAIL b2b_last_data: got %h want 3", data_out); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_missing_pulse: %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_frame();
    int t; logic b;
    rx = 1'b0;
    t  = cyc + 1;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    while (cyc < t + 9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    n_tests++; if (data_out !== 4'h0) begin n_fail++; $display("FAIL rst_mid_data_out: got %h want 0", data_out); end
    exp_data = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    repeat (16) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_idle: got %b want 0", busy); end
    send_frame(4'h3, 1'b1, CPB, t, b);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (data_out !== 4'h3) begin n_fail++; $display("FAIL rst_mid_next_data: got %h want 3", data_out); end
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_missing_pulse: %0d pending want 0", exp_q.size()); exp_q.delete(); end
  endtask

  initial begin
    n_tests  = 0;
    n_fail   = 0;
    exp_data = 4'h0;
    reset    = 1'b0;
    rx       = 1'b1;
    // Scoreboard monitor: every pulse must match the oldest expected event.
    fork
      forever begin
        @(negedge clk);
        if (fn === 1'b1 || frame_err === 1'b1) begin
          n_tests++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_pulse: fn=%b frame_err=%b at edge %0d, want no pulse", fn, frame_err, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (fn !== e.fn || frame_err !== e.ferr || data_out !== e.data || cyc != e.cyc) begin
              n_fail++;
              $display("FAIL scoreboard_pulse: got fn=%b ferr=%b data=%h edge=%0d want fn=%b ferr=%b data=%h edge=%0d",
                       fn, frame_err, data_out, cyc, e.fn, e.ferr, e.data, e.cyc);
            end
          end
        end
      end
    join_none
    test_reset();
    @(negedge clk);
    test_good_frame();
    test_false_start();
    test_frame_error();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
